vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_delay_line.sv | 22 ++
 rtl/vga_timing_gen.sv | 77 +++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, colours and cube kinds shared by the VGA path.
package vga_timing_pkg;
  localparam logic [9:0] H_DISP  = 10'd640;
  localparam logic [9:0] H_FRONT = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BACK  = 10'd48;
  localparam logic [9:0] V_DISP  = 10'd480;
  localparam logic [9:0] V_FRONT = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BACK  = 10'd33;
  localparam logic [9:0] H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] BLUE   = 24'h0000FF;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;
  typedef enum logic [1:0] {NONE, HEAD, BODY, WALL} cube_kind_e;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;
  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-stage clock-enabled delay line of W-bit words with async active-low clear.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_pipe [D];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pipe <= '{default: '0};
    else if (i_ce) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < D; i++) r_pipe[i] <= r_pipe[i-1];
    end
  assign o_q = r_pipe[D-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan counters, sync generation and colour-stage alignment to the DAC pins.
module vga_timing_gen #(
  parameter logic [9:0] H_DISP   = vga_timing_pkg::H_DISP,
  parameter logic [9:0] H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter logic [9:0] H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter logic [9:0] H_BACK   = vga_timing_pkg::H_BACK,
  parameter logic [9:0] V_DISP   = vga_timing_pkg::V_DISP,
  parameter logic [9:0] V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter logic [9:0] V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter logic [9:0] V_BACK   = vga_timing_pkg::V_BACK,
  parameter int         DATA_LAT = 1,
  parameter logic       SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic [23:0] vga_data,
  output logic [9:0]  vga_xpos,
  output logic [9:0]  vga_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb,
  output logic        vblank_start
);
  import vga_timing_pkg::*;
  localparam logic [9:0] H_TOT = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] V_TOT = V_DISP + V_FRONT + V_SYNC + V_BACK;
  logic [9:0]  r_h, r_v;
  logic        w_h_end, w_v_end, w_active;
  sync_t       w_raw, w_dly;
  logic        r_hs, r_vs, r_de;
  logic [23:0] r_rgb;
  assign w_h_end = r_h == H_TOT - 10'd1;
  assign w_v_end = r_v == V_TOT - 10'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_ce) begin
      r_h <= w_h_end ? 10'd0 : r_h + 10'd1;
      if (w_h_end) r_v <= w_v_end ? 10'd0 : r_v + 10'd1;
    end
  always_comb begin
    w_active = (r_h < H_DISP) && (r_v < V_DISP);
    w_raw.hs = in_range(r_h, H_DISP + H_FRONT, H_DISP + H_FRONT + H_SYNC);
    w_raw.vs = in_range(r_v, V_DISP + V_FRONT, V_DISP + V_FRONT + V_SYNC);
    w_raw.de = w_active;
  end
  // sync and de travel alongside the colour stage so all pins line up
  vga_delay_line #(.W($bits(sync_t)), .D(DATA_LAT)) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ce  (pix_ce),
    .i_d   (w_raw),
    .o_q   (w_dly)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else if (pix_ce) begin
      r_hs  <= w_dly.hs ~^ SYNC_POL;
      r_vs  <= w_dly.vs ~^ SYNC_POL;
      r_de  <= w_dly.de;
      r_rgb <= w_dly.de ? vga_data : 24'h0;
    end
  assign vga_xpos     = w_active ? r_h : 10'd0;
  assign vga_ypos     = w_active ? r_v : 10'd0;
  assign vga_hs       = r_hs;
  assign vga_vs       = r_vs;
  assign vga_de       = r_de;
  assign vga_rgb      = r_rgb;
  assign vblank_start = pix_ce && w_h_end && (r_v == V_DISP - 10'd1);
endmodule
